// File: rtl/sram_1rw1r_wmask_model.sv
// sram_1rw1r_wmask_model: behavioural SRAM, port 0 read/write with per-lane write mask,
// port 1 read-only, plus a clear engine that zeroes the whole array one word per cycle.
// Optional macro SRAM_COLLISION_DETECT_EN adds a registered "collision" flag for
// same-address port 0 write / port 1 read in one cycle.
module sram_1rw1r_wmask_model #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WMASK_WIDTH = 8,
    parameter int unsigned NUM_WMASKS  = DATA_WIDTH / WMASK_WIDTH,
    parameter bit          VERBOSE     = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    input  logic                  clr,
    output logic                  busy
`ifdef SRAM_COLLISION_DETECT_EN
    ,
    output logic                  collision
`endif
);

    localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : gen_bad_width
        $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [0:0]            state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  clr_we;
    logic                  acc0;
    logic                  wr0;
    logic                  rd0;
    logic                  rd1;

    // While the clear engine runs both ports look deselected.
    assign busy   = (state_q == StClear);
    assign acc0   = !csb0 && !busy;
    assign wr0    = acc0 && !web0;
    assign rd0    = acc0 && web0;
    assign rd1    = !csb1 && !busy;
    // A reset in the same cycle aborts the clear before it touches the current word.
    assign clr_we = busy && !rst0;

    // Clear FSM and word counter; reset wins over a clr request.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clr) state_q <= StClear;
                end
                default: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) state_q <= StIdle;
                end
            endcase
        end
    end

    // Array update: clear engine word or masked port 0 write (mutually exclusive via busy).
    always_ff @(posedge clk0) begin
        if (clr_we) begin
            mem[cnt_q] <= '0;
        end else if (wr0) begin
            for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) mem[addr0][i*WMASK_WIDTH +: WMASK_WIDTH] <= din0[i*WMASK_WIDTH +: WMASK_WIDTH];
            end
        end
    end

    // Registered read data; old array contents are seen, giving read-before-write.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            dout0 <= '0;
            dout1 <= '0;
        end else begin
            if (rd0) dout0 <= mem[addr0];
            if (rd1) dout1 <= mem[addr1];
        end
    end

`ifdef SRAM_COLLISION_DETECT_EN
    logic coll_hit;
    assign coll_hit = wr0 && (|wmask0) && rd1 && (addr0 == addr1);

    // One-cycle flag for a same-address write/read pair.
    always_ff @(posedge clk0) begin
        if (rst0) collision <= 1'b0;
        else      collision <= coll_hit;
    end

`ifndef SYNTHESIS
    // Collision warning, printed whatever VERBOSE is set to.
    always_ff @(posedge clk0) begin
        if (!rst0 && coll_hit) begin
            $display("%0t %m: warning, port 0 write and port 1 read at addr 0x%0h", $time, addr0);
        end
    end
`endif
`endif

`ifndef SYNTHESIS
    // Access trace for simulation.
    always_ff @(posedge clk0) begin
        if (VERBOSE && !rst0) begin
            if (wr0) $display("%0t %m: write0 addr 0x%0h data 0x%0h mask 0x%0h", $time, addr0, din0, wmask0);
            if (rd0) $display("%0t %m: read0 addr 0x%0h data 0x%0h", $time, addr0, mem[addr0]);
            if (rd1) $display("%0t %m: read1 addr 0x%0h data 0x%0h", $time, addr1, mem[addr1]);
        end
    end
`endif

endmodule
